// File: rtl/instr_fetch_resp.sv
// Instruction-fetch responder: accepts PC requests, reads the synchronous instruction
// memory and buffers {pc, word, err} entries in a small FIFO for the decode stage.
module instr_fetch_resp #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_pc,
   input  logic              flush,
   output logic              imem_en,
   output logic [ADDR_W-3:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [31:0]       ins_data,
   output logic [ADDR_W-1:0] ins_pc,
   output logic              ins_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(DEPTH);

   logic [31:0]       fifo_data [DEPTH];
   logic [ADDR_W-1:0] fifo_pc   [DEPTH];
   logic              fifo_err  [DEPTH];

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;

   logic              inf_valid;
   logic [ADDR_W-1:0] inf_pc;
   logic              inf_err;

   logic              accept;
   logic              misaligned;
   logic              push;
   logic              pop;
   logic [PTR_W+1:0]  occupancy;

   // A slot is reserved for the in-flight fetch, so buffered + in-flight bounds acceptance.
   assign occupancy  = {1'b0, count} + {{(PTR_W+1){1'b0}}, inf_valid};
   assign req_ready  = rst_n && !flush && (occupancy < DEPTH_L);
   assign accept     = req_valid && req_ready;
   assign misaligned = (req_pc[1:0] != 2'b00);

   assign imem_en    = accept && !misaligned;
   assign imem_addr  = req_pc[ADDR_W-1:2];

   assign ins_valid  = (count != '0);
   assign push       = inf_valid && !flush;
   assign pop        = ins_valid && ins_ready && !flush;

   assign ins_data   = ins_valid ? fifo_data[rd_ptr] : '0;
   assign ins_pc     = ins_valid ? fifo_pc[rd_ptr]   : '0;
   assign ins_err    = ins_valid && fifo_err[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         inf_valid <= 1'b0;
         inf_pc    <= '0;
         inf_err   <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         inf_valid <= 1'b0;
      end else begin
         inf_valid <= accept;
         if (accept) begin
            inf_pc  <= req_pc;
            inf_err <= misaligned;
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the head outputs are masked whenever count is zero.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= inf_err ? '0 : imem_rdata;
         fifo_pc[wr_ptr]   <= inf_pc;
         fifo_err[wr_ptr]  <= inf_err;
      end
   end

endmodule
